// File: rtl/audio_ram_ctrl_if.sv
// rtl/audio_ram_ctrl_if.sv - sample loader write port and frame output bundle of audio_ram_ctrl
interface audio_ram_ctrl_if #(
  parameter int ADDR_W = 23,
  parameter int NUM_CH = 2
);
  logic                 wr_req;
  logic [ADDR_W-1:0]    wr_addr;
  logic [15:0]          wr_data;
  logic                 wr_ack;
  logic [16*NUM_CH-1:0] sample_data;
  logic                 sample_valid;

  modport master (
    output wr_req, wr_addr, wr_data,
    input  wr_ack, sample_data, sample_valid
  );

  modport slave (
    input  wr_req, wr_addr, wr_data,
    output wr_ack, sample_data, sample_valid
  );
endinterface

// File: rtl/audio_ram_ctrl.sv
// rtl/audio_ram_ctrl.sv - PSRAM audio playback controller; write port enabled by SYNTH_RAM_WRITE_EN
module audio_ram_ctrl #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SAMPLE_HZ   = 48_000,
  parameter int ADDR_W      = 23,
  parameter int NUM_CH      = 2,
  parameter int WAIT_CYCLES = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play_en,
  input  logic [ADDR_W-1:0] loop_end,
  audio_ram_ctrl_if.slave   bus,
  output logic              underrun,
  output logic [22:0]       MemAdr,
  inout  wire  [15:0]       MemDB,
  output logic              RamAdv,
  output logic              RamClk,
  output logic              RamCS,
  output logic              MemOE,
  output logic              MemWR,
  output logic              RamLB,
  output logic              RamUB
);

  localparam int DIV    = CLK_HZ / SAMPLE_HZ;
  localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int WAIT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // {Adv, Clk, CS, OE, WR, LB, UB}, all active-low
  localparam logic [6:0] CTRL_IDLE = 7'b1111111;
  localparam logic [6:0] CTRL_RD   = 7'b0000100;
`ifdef SYNTH_RAM_WRITE_EN
  localparam logic [6:0] CTRL_WR   = 7'b0001000;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
`ifdef SYNTH_RAM_WRITE_EN
    S_WR,
`endif
    S_REC
  } state_t;

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 tick_q;
  state_t               state_q;
  logic [WAIT_W-1:0]    wait_q;
  logic [CH_W-1:0]      ch_q;
  logic [ADDR_W-1:0]    frame_ptr_q;
  logic                 frame_pend_q;
  logic                 underrun_q;
  logic                 sample_valid_q;
  logic [16*NUM_CH-1:0] sample_q;
  logic [6:0]           ctrl_q;
  logic [22:0]          adr_q;
`ifdef SYNTH_RAM_WRITE_EN
  logic                 wr_ack_q;
  logic                 db_oe_q;
`endif

  logic              tick_start;
  logic              read_req;
  logic              wait_done;
  logic              last_ch;
  logic [ADDR_W:0]   ptr_sum;
  logic [ADDR_W-1:0] ptr_next;

  // A tick only counts while playing; a pending frame or a fresh tick both request a fetch
  assign tick_start = tick_q & play_en;
  assign read_req   = frame_pend_q | tick_start;
  assign wait_done  = (wait_q == WAIT_W'(WAIT_CYCLES));
  assign last_ch    = (ch_q == CH_W'(NUM_CH - 1));
  assign ptr_sum    = {1'b0, frame_ptr_q} + (ADDR_W + 1)'(NUM_CH);
  assign ptr_next   = (ptr_sum > {1'b0, loop_end}) ? '0 : ptr_sum[ADDR_W-1:0];

  function automatic logic [22:0] to_mem_adr(input logic [ADDR_W-1:0] a);
    return 23'(a);
  endfunction

  // Sample-rate divider: counts 0..DIV-1
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == CNT_W'(DIV - 1)) cnt_d = '0;
  end

  // Divider state and registered one-cycle tick on the wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_q == CNT_W'(DIV - 1));
    end
  end

  // Access sequencer: tick bookkeeping, frame reads, loader writes, registered PSRAM controls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      wait_q         <= '0;
      ch_q           <= '0;
      frame_ptr_q    <= '0;
      frame_pend_q   <= 1'b0;
      underrun_q     <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_q       <= '0;
      ctrl_q         <= CTRL_IDLE;
      adr_q          <= '0;
`ifdef SYNTH_RAM_WRITE_EN
      wr_ack_q       <= 1'b0;
      db_oe_q        <= 1'b0;
`endif
    end else begin
      sample_valid_q <= 1'b0;
`ifdef SYNTH_RAM_WRITE_EN
      wr_ack_q       <= 1'b0;
`endif
      // A second tick while a frame is still outstanding is dropped and flagged
      if (tick_start) begin
        if (frame_pend_q) underrun_q   <= 1'b1;
        else              frame_pend_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          wait_q <= '0;
          if (read_req) begin
            state_q <= S_RD;
            ctrl_q  <= CTRL_RD;
            adr_q   <= to_mem_adr(frame_ptr_q);
            ch_q    <= '0;
          end
`ifdef SYNTH_RAM_WRITE_EN
          else if (bus.wr_req) begin
            state_q <= S_WR;
            ctrl_q  <= CTRL_WR;
            adr_q   <= to_mem_adr(bus.wr_addr);
            db_oe_q <= 1'b1;
          end
`endif
        end

        S_RD: begin
          if (wait_done) begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (ch_q == CH_W'(k)) sample_q[16*k +: 16] <= MemDB;
            end
            sample_valid_q <= last_ch;
            ctrl_q         <= CTRL_IDLE;
            wait_q         <= '0;
            state_q        <= S_REC;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end

`ifdef SYNTH_RAM_WRITE_EN
        S_WR: begin
          if (wait_done) begin
            wr_ack_q <= 1'b1;
            db_oe_q  <= 1'b0;
            ctrl_q   <= CTRL_IDLE;
            wait_q   <= '0;
            state_q  <= S_REC;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
`endif

        S_REC: begin
          wait_q <= '0;
`ifdef SYNTH_RAM_WRITE_EN
          // wr_ack_q is high only in the recovery cycle that follows a write
          if (wr_ack_q) begin
            state_q <= S_IDLE;
          end else
`endif
          if (!last_ch) begin
            ch_q    <= ch_q + 1'b1;
            adr_q   <= adr_q + 23'd1;
            ctrl_q  <= CTRL_RD;
            state_q <= S_RD;
          end else begin
            frame_pend_q <= 1'b0;
            frame_ptr_q  <= ptr_next;
            ch_q         <= '0;
            state_q      <= S_IDLE;
`ifdef SYNTH_RAM_WRITE_EN
            // A loader write that waited behind the frame starts straight away
            if (bus.wr_req) begin
              state_q <= S_WR;
              ctrl_q  <= CTRL_WR;
              adr_q   <= to_mem_adr(bus.wr_addr);
              db_oe_q <= 1'b1;
            end
`endif
          end
        end

        default: begin
          state_q <= S_IDLE;
          ctrl_q  <= CTRL_IDLE;
        end
      endcase
    end
  end

  assign {RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB} = ctrl_q;
  assign MemAdr           = adr_q;
  assign underrun         = underrun_q;
  assign bus.sample_data  = sample_q;
  assign bus.sample_valid = sample_valid_q;

`ifdef SYNTH_RAM_WRITE_EN
  assign bus.wr_ack = wr_ack_q;
  assign MemDB      = db_oe_q ? bus.wr_data : 16'hzzzz;
`else
  logic unused_wr;
  assign unused_wr  = ^{bus.wr_req, bus.wr_addr, bus.wr_data};
  assign bus.wr_ack = 1'b0;
  assign MemDB      = 16'hzzzz;
`endif

endmodule

// File: tb/tb_audio_ram_ctrl.sv
// tb/tb_audio_ram_ctrl.sv - self-checking bench for audio_ram_ctrl with PSRAM model and frame scoreboard
module tb_audio_ram_ctrl;

  localparam int CLK_HZ      = 100_000_000;
  localparam int SAMPLE_HZ   = 48_000;
  localparam int DIV         = CLK_HZ / SAMPLE_HZ;
  localparam int NUM_CH      = 2;
  localparam int WAIT_CYCLES = 6;
  localparam int LAT         = NUM_CH * (WAIT_CYCLES + 2);
  localparam int WIN         = 36;
`ifdef SYNTH_RAM_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        play_en, play_en2;
  logic [22:0] loop_end;
  wire  [15:0] mem_db, mem_db2;
  logic [22:0] mem_adr, mem_adr2;
  logic        ram_adv, ram_clk, ram_cs, mem_oe, mem_wr, ram_lb, ram_ub, underrun;
  logic        ram_adv2, ram_clk2, ram_cs2, mem_oe2, mem_wr2, ram_lb2, ram_ub2, underrun2;

  audio_ram_ctrl_if #(.ADDR_W(23), .NUM_CH(NUM_CH)) bus ();
  audio_ram_ctrl_if #(.ADDR_W(23), .NUM_CH(NUM_CH)) bus2 ();

  audio_ram_ctrl #(.CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .ADDR_W(23), .NUM_CH(NUM_CH),
                   .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .rst(rst), .play_en(play_en), .loop_end(loop_end), .bus(bus.slave),
    .underrun(underrun), .MemAdr(mem_adr), .MemDB(mem_db), .RamAdv(ram_adv), .RamClk(ram_clk),
    .RamCS(ram_cs), .MemOE(mem_oe), .MemWR(mem_wr), .RamLB(ram_lb), .RamUB(ram_ub));

  audio_ram_ctrl #(.CLK_HZ(10 * SAMPLE_HZ), .SAMPLE_HZ(SAMPLE_HZ), .ADDR_W(23), .NUM_CH(NUM_CH),
                   .WAIT_CYCLES(WAIT_CYCLES)) dut_fast (
    .clk(clk), .rst(rst), .play_en(play_en2), .loop_end(23'd3), .bus(bus2.slave),
    .underrun(underrun2), .MemAdr(mem_adr2), .MemDB(mem_db2), .RamAdv(ram_adv2), .RamClk(ram_clk2),
    .RamCS(ram_cs2), .MemOE(mem_oe2), .MemWR(mem_wr2), .RamLB(ram_lb2), .RamUB(ram_ub2));

  always #5 clk = ~clk;

  wire [6:0] ctrl = {ram_adv, ram_clk, ram_cs, mem_oe, mem_wr, ram_lb, ram_ub};

  logic [15:0] mem     [256];
  logic [15:0] exp_mem [256];
  logic [15:0] rd_word;
  assign rd_word = mem[mem_adr[7:0]];
  assign mem_db  = (!ram_cs && !mem_oe) ? rd_word : 16'hzzzz;
  assign mem_db2 = (!ram_cs2 && !mem_oe2) ? 16'h0000 : 16'hzzzz;

  int cyc;
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic        play_en;
    int          exp_pulses;
    logic [31:0] exp_data;
  } vec_t;
  vec_t tbl[5];

  int          errors = 0;
  int          checks = 0;
  logic [22:0] m_ptr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_tick(output int t);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(cyc != 0 && cyc % DIV == 0) && n < DIV + 4);
    if (n >= DIV + 4) check("tick_timeout", 64'(n), 64'(DIV));
    t = cyc;
  endtask

  task automatic window(output int pulses, output int sv_cyc, output int ack_cyc,
                        output int wr_low, output int db_bad);
    pulses = 0; sv_cyc = -1; ack_cyc = -1; wr_low = 0; db_bad = 0;
    for (int i = 0; i < WIN; i++) begin
      @(negedge clk);
      if (bus.sample_valid) begin
        pulses++;
        sv_cyc = cyc;
      end
      if (!mem_wr) begin
        wr_low++;
        if (mem_db !== bus.wr_data) db_bad++;
      end
      if (bus.wr_ack) begin
        ack_cyc = cyc;
        bus.wr_req = 1'b0;
      end
    end
    bus.wr_req = 1'b0;
  endtask

  initial begin
    int t, r, pulses, sv_cyc, ack_cyc, wr_low, db_bad, bad;
    exp_t e;

    tbl[0] = '{1'b1, 1, 32'h2222_1111};
    tbl[1] = '{1'b1, 1, 32'h4444_3333};
    tbl[2] = '{1'b1, 1, 32'h2222_1111};
    tbl[3] = '{1'b0, 0, 32'h2222_1111};
    tbl[4] = '{1'b1, 1, 32'h4444_3333};

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    mem[4] = 16'h5555; mem[5] = 16'h6666; mem[6] = 16'h7777; mem[7] = 16'h8888;
    for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
    m_ptr = '0;

    rst = 1'b1; play_en = 1'b0; play_en2 = 1'b1; loop_end = 23'd3;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus2.wr_req = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ctrl", 64'(ctrl), 64'h7F);
    check("rst_memadr", 64'(mem_adr), 64'h0);
    check("rst_sample_data", 64'(bus.sample_data), 64'h0);
    check("rst_flags", 64'({bus.sample_valid, bus.wr_ack, underrun, underrun2}), 64'h0);
    rst = 1'b1;

    // Scoreboard: PSRAM write capture, frame prediction on each tick, pulse checking
    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          if (!ram_cs && !mem_wr) mem[mem_adr[7:0]] = mem_db;
          if (cyc != 0 && cyc % DIV == 0 && play_en) begin
            e.data = {exp_mem[8'(m_ptr + 23'd1)], exp_mem[8'(m_ptr)]};
            e.due  = cyc + LAT;
            sbq.push_back(e);
            m_ptr = (m_ptr + 23'd2 > loop_end) ? 23'd0 : m_ptr + 23'd2;
          end
          if (bus.sample_valid) begin
            if (sbq.size() == 0) begin
              check("sv_unexpected", 64'(cyc), 64'(-1));
            end else begin
              e = sbq.pop_front();
              check("sv_cycle", 64'(cyc), 64'(e.due));
              check("sv_data", 64'(bus.sample_data), 64'(e.data));
            end
          end else if (sbq.size() != 0 && cyc > sbq[0].due) begin
            check("sv_late", 64'(cyc), 64'(sbq[0].due));
            void'(sbq.pop_front());
          end
        end
      end
    join_none

    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (ctrl != 7'h7F || mem_adr != 23'd0 || bus.sample_valid) bad++;
      if (cyc == 20) check("underrun_before_2nd_tick", 64'(underrun2), 64'h0);
      if (cyc == 21) check("underrun_on_2nd_tick", 64'(underrun2), 64'h1);
    end
    check("idle_no_activity", 64'(bad), 64'h0);
    check("underrun_sticky", 64'(underrun2), 64'h1);

    for (int i = 0; i < 5; i++) begin
      play_en = tbl[i].play_en;
      wait_tick(t);
      window(pulses, sv_cyc, ack_cyc, wr_low, db_bad);
      check($sformatf("tbl%0d_pulses", i), 64'(pulses), 64'(tbl[i].exp_pulses));
      check($sformatf("tbl%0d_data", i), 64'(bus.sample_data), 64'(tbl[i].exp_data));
      if (tbl[i].exp_pulses != 0) check($sformatf("tbl%0d_latency", i), 64'(sv_cyc), 64'(t + LAT));
    end

    bus.wr_addr = 23'd5; bus.wr_data = 16'hBEEF; bus.wr_req = 1'b1;
    r = cyc;
    if (WR_EN) exp_mem[5] = 16'hBEEF;
    window(pulses, sv_cyc, ack_cyc, wr_low, db_bad);
    check("wr_memwr_low_cycles", 64'(wr_low), WR_EN ? 64'd7 : 64'd0);
    check("wr_memdb_value", 64'(db_bad), 64'h0);
    check("wr_ack_cycle", 64'(ack_cyc), WR_EN ? 64'(r + WAIT_CYCLES + 2) : 64'(-1));

    wait_tick(t);
    bus.wr_addr = 23'd6; bus.wr_data = 16'hCAFE; bus.wr_req = 1'b1;
    if (WR_EN) exp_mem[6] = 16'hCAFE;
    window(pulses, sv_cyc, ack_cyc, wr_low, db_bad);
    check("same_cycle_sv", 64'(sv_cyc), 64'(t + LAT));
    check("same_cycle_data", 64'(bus.sample_data), 64'h2222_1111);
    check("same_cycle_ack", 64'(ack_cyc), WR_EN ? 64'(t + LAT + WAIT_CYCLES + 2) : 64'(-1));
    check("same_cycle_memwr_low", 64'(wr_low), WR_EN ? 64'd7 : 64'd0);

    play_en = 1'b0;
    @(negedge clk);
    loop_end = 23'd7;
    play_en  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_tick(t);
      window(pulses, sv_cyc, ack_cyc, wr_low, db_bad);
      if (i == 1) check("readback_addr5", 64'(bus.sample_data),
                        64'({WR_EN ? 16'hBEEF : 16'h6666, 16'h5555}));
      if (i == 2) check("readback_addr6", 64'(bus.sample_data),
                        64'({16'h8888, WR_EN ? 16'hCAFE : 16'h7777}));
    end

    wait_tick(t);
    window(pulses, sv_cyc, ack_cyc, wr_low, db_bad);
    check("pre_reset_frame", 64'(bus.sample_data), 64'h2222_1111);

    wait_tick(t);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrd_rst_ctrl", 64'(ctrl), 64'h7F);
    check("midrd_rst_pulses", 64'({bus.sample_valid, bus.wr_ack}), 64'h0);
    sbq.delete();
    m_ptr = '0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.sample_valid) bad++;
    end
    check("midrd_rst_no_valid", 64'(bad), 64'h0);
    check("midrd_rst_sample_data", 64'(bus.sample_data), 64'h0);
    rst = 1'b1;

    wait_tick(t);
    window(pulses, sv_cyc, ack_cyc, wr_low, db_bad);
    check("post_reset_pulses", 64'(pulses), 64'h1);
    check("post_reset_ptr_zero", 64'(bus.sample_data), 64'h2222_1111);
    check("post_reset_latency", 64'(sv_cyc), 64'(t + LAT));

    check("main_underrun_clear", 64'(underrun), 64'h0);
    check("scoreboard_drained", 64'(sbq.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_ram_ctrl.md
# audio_ram_ctrl

- Parametrised playback controller for the board's asynchronous PSRAM.
- Generates the audio sample-rate tick and fetches one frame of `NUM_CH` 16-bit words per tick from a looping address region.
- Presents the frame to the audio output path with a one-cycle valid strobe.
- Arbitrates a request/acknowledge write port, used by the sample loader, into the gaps between frame fetches.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: system clock frequency.
- `SAMPLE_HZ`, 48_000: frame rate; `DIV = CLK_HZ/SAMPLE_HZ` (integer division).
- `ADDR_W`, 23: word address width (≤ 23); zero-extended onto `MemAdr`.
- `NUM_CH`, 2: words per frame (1..8).
- `WAIT_CYCLES`, 6: extra cycles an access is held beyond its first cycle.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `play_en`  in  1  when high, ticks launch frame fetches.
- `loop_end`  in  ADDR_W  last word address of the loop region; static while `play_en` is high.
- `wr_req`  in  1  write request; hold high until `wr_ack`.
- `wr_addr`  in  ADDR_W  write word address; stable while `wr_req` is high.
- `wr_data`  in  16  write data; stable while `wr_req` is high.
- `wr_ack`  out  1  one-cycle pulse when the write completes.
- `sample_data`  out  16*NUM_CH  last fetched frame; channel 0 in bits [15:0].
- `sample_valid`  out  1  one-cycle pulse when `sample_data` updates.
- `underrun`  out  1  sticky; set if a tick arrives while a frame is still pending.
- `MemAdr`  out  23  PSRAM address.
- `MemDB`  inout  16  PSRAM data bus.
- `RamAdv`, `RamClk`, `RamCS`, `MemOE`, `MemWR`, `RamLB`, `RamUB`  out  1 each  PSRAM controls, all active-low.

## Operation
**Tick generator**
- Counter runs 0..DIV-1 and wraps.
- Registered `tick` pulses for one cycle on the wrap.

**Tick handling**
- Tick with `play_en` high sets `frame_pend`.
- Tick with `frame_pend` already set sets `underrun`; the extra tick is dropped.
- Tick with `play_en` low is ignored; the pointer holds.

**Frame fetch**
- Read words `frame_ptr + 0 .. frame_ptr + NUM_CH-1` in order.
- Word *k* is captured into channel *k*.
- After the last word: `frame_ptr <= (frame_ptr + NUM_CH > loop_end) ? 0 : frame_ptr + NUM_CH`.
- `loop_end + 1` must be a multiple of `NUM_CH`.

**FSM states**
- IDLE: controls 7'b1111111, `MemDB` Z. Goes to RD if `frame_pend`, else to WR if `wr_req`, else stays. Reads take priority.
- RD: controls {Adv,Clk,CS,OE,WR,LB,UB} = 7'b0000100. Held WAIT_CYCLES+1 cycles. `MemDB` is sampled on the edge leaving RD, then go to REC.
- WR: controls 7'b0001000. `MemDB` driven with `wr_data`. Held WAIT_CYCLES+1 cycles, then go to REC.
- REC: one cycle, controls idle, `MemDB` Z.
  - After a non-final frame read: go to RD with the next channel.
  - After the final read: `sample_valid` = 1, clear `frame_pend`, go to IDLE.
  - After a write: `wr_ack` = 1, go to IDLE.

**Addressing**
- `MemAdr` is registered and loaded on entry to RD/WR.
- It holds through REC.

**Reset**
- Reset asserted mid-access aborts immediately; no `wr_ack` or `sample_valid` is produced.
- Reset values:
  - all control outputs high; `MemDB` Z; `MemAdr` 0
  - `sample_data` 0; `sample_valid`, `wr_ack`, `underrun` 0
  - `frame_ptr` 0; tick counter 0; state IDLE

## Timing
- Access length: WAIT_CYCLES+2 cycles, i.e. WAIT_CYCLES+1 active plus 1 REC.
- Tick at cycle t with FSM in IDLE:
  - RD entered at t+1.
  - `sample_valid` high at t + NUM_CH*(WAIT_CYCLES+2).
  - Defaults (NUM_CH=2, WAIT_CYCLES=6): t+16.
- Tick arriving during a write: the fetch starts after that write's REC. Worst-case added latency is WAIT_CYCLES+2.
- Write latency from `wr_req` rise in IDLE (no pending frame): `wr_ack` at +WAIT_CYCLES+2.
- Design requirement: `DIV > (NUM_CH+1)*(WAIT_CYCLES+2)`. Meeting it means `underrun` never sets under legal write traffic.
- `wr_req` and tick in the same cycle: the read wins; the write waits for the whole frame.

## Configuration
- Macro `SYNTH_RAM_WRITE_EN`.
- Defined: write port and WR state as specified.
- Undefined:
  - WR state removed; `wr_req`, `wr_addr`, `wr_data` ignored.
  - `wr_ack` tied 0; `MemWR` constant 1; `MemDB` never driven.

## Test plan
- Reset release, `play_en`=0, 10 000 cycles: controls stay 7'b1111111, `MemDB` Z, `sample_valid` never pulses.
- Preload words 0..3 = 16'h1111, 16'h2222, 16'h3333, 16'h4444; `loop_end`=3; `play_en`=1:
  - ticks 1 and 2 give `sample_data` 32'h2222_1111 then 32'h4444_3333;
  - tick 3 wraps back to 32'h2222_1111;
  - `sample_valid` exactly 16 cycles after each tick.
- `wr_req` with addr 5, data 16'hBEEF in IDLE: `MemWR` low for 7 cycles, `MemDB` = BEEF, `wr_ack` at +8; a later read of addr 5 returns BEEF.
- `wr_req` and tick in the same cycle: frame reads complete first (`sample_valid` at +16); `wr_ack` at +24.
- DIV forced small (CLK_HZ = 10*SAMPLE_HZ), `NUM_CH`=2: `underrun` sets on the second tick and stays set.
- `rst` asserted mid-RD: all controls high asynchronously, `sample_valid` 0, `frame_ptr` back to 0.
